vga_scan_ctrl: RTL and testbench

Display-timing and scan controller for the VGA frame buffer read port. Generates raster counters, hsync/vsync, and the pixel-addressable px_addr that drives the frame buffer on pxclk. Realigns the returned px_data with sync and data-enable so the DAC/pin stage receives a coherent pixel stream. Sits between the frame buffer and the VGA output pins.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 rtl/vga_scan_ctrl.sv | 110 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing defaults for the VGA scan path.
// VGA_SCAN_DOUBLE_EN selects 2x2 pixel doubling in the scan controller.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    V_ACT,
    V_FP,
    V_SP,
    V_BP
  } vert_state_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic vb;
    logic fs;
    logic inc;
  } ctl_t;

  localparam ctl_t CTL_RST = '{
    de: 1'b0, hs: 1'b0, vs: 1'b0,
    vb: 1'b1, fs: 1'b0, inc: 1'b0
  };

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int PIPE_LAT     = 3;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, vertical FSM and active-high sync/de/vblank flags.
// VGA_SCAN_DOUBLE_EN: line base advances only after odd visible lines.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int HW = 10,
  parameter int VW = 10
) (
  input  logic          pxclk,
  input  logic          rst_n,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic          base_adv,
  output ctl_t          ctl
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HW-1:0] HL_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HL_SS  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HL_SE  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] HL_END = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VL_ACT = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VL_FP  = VW'(V_ACTIVE + V_FRONT - 1);
  localparam logic [VW-1:0] VL_SP  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] VL_END = VW'(V_TOTAL - 1);

  vert_state_t   state, state_n;
  logic [HW-1:0] h_n;
  logic [VW-1:0] v_cnt, v_n;
  logic          line_end;
  logic          act;
  logic          seen;

  assign line_end = (h_cnt == HL_END);
  assign act      = (state == V_ACT);

  always_comb begin
    state_n = state;
    h_n     = h_cnt;
    v_n     = v_cnt;
    if (state == IDLE) begin
      h_n = '0;
      v_n = '0;
      if (enable) state_n = V_ACT;
    end else if (line_end) begin
      h_n = '0;
      v_n = v_cnt + 1'b1;
      unique case (state)
        V_ACT: if (v_cnt == VL_ACT) state_n = V_FP;
        V_FP:  if (v_cnt == VL_FP) state_n = V_SP;
        V_SP:  if (v_cnt == VL_SP) state_n = V_BP;
        V_BP:  if (v_cnt == VL_END) begin
          v_n     = '0;
          state_n = enable ? V_ACT : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      h_n = h_cnt + 1'b1;
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      h_cnt <= h_n;
      v_cnt <= v_n;
      seen  <= (state == IDLE) ? 1'b0 : (seen | ctl.fs);
    end
  end

  always_comb begin
    ctl     = CTL_RST;
    ctl.de  = act && (h_cnt < HL_ACT);
    ctl.hs  = (state != IDLE) && (h_cnt >= HL_SS) && (h_cnt <= HL_SE);
    ctl.vs  = (state == V_SP);
    ctl.vb  = !act;
    ctl.fs  = act && (h_cnt == '0) && (v_cnt == '0);
    // first frame after reset/IDLE does not count
    ctl.inc = ctl.fs && seen;
  end

`ifdef VGA_SCAN_DOUBLE_EN
  assign base_adv = line_end && act && v_cnt[0];
`else
  assign base_adv = line_end && act;
`endif

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: address generation and 3-stage output alignment.
// VGA_SCAN_DOUBLE_EN: 2x2 pixel doubling from a quarter-size buffer.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int H_FRONT         = VGA_H_FRONT,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BACK          = VGA_H_BACK,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter int V_FRONT         = VGA_V_FRONT,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BACK          = VGA_V_BACK,
  parameter int PIXEL_DEPTH     = 8,
  parameter int SYNC_ACTIVE_LOW = 1,
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                   pxclk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic [AW-1:0]          px_addr,
  input  logic [PIXEL_DEPTH-1:0] px_data,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [PIXEL_DEPTH-1:0] pixel,
  output logic                   vblank,
  output logic                   frame_start,
  output logic [15:0]            frame_count
);

  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam int VW = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

`ifdef VGA_SCAN_DOUBLE_EN
  localparam logic [AW-1:0] STEP = AW'(H_ACTIVE / 2);
`else
  localparam logic [AW-1:0] STEP = AW'(H_ACTIVE);
`endif

  logic [HW-1:0] h_cnt;
  logic          base_adv;
  logic [AW-1:0] line_base;
  logic [AW-1:0] col;
  ctl_t          ctl, s1, s2;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .pxclk    (pxclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .h_cnt    (h_cnt),
    .base_adv (base_adv),
    .ctl      (ctl)
  );

`ifdef VGA_SCAN_DOUBLE_EN
  assign col = AW'(h_cnt >> 1);
`else
  assign col = AW'(h_cnt);
`endif

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      line_base <= '0;
      px_addr   <= '0;
      s1        <= CTL_RST;
      s2        <= CTL_RST;
    end else begin
      if (ctl.vb) line_base <= '0;
      else if (base_adv) line_base <= line_base + STEP;
      px_addr <= ctl.de ? (line_base + col) : '0;
      s1      <= ctl;
      s2      <= s1;
    end
  end

  // s2 lines up with px_data for the address issued from s1
  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      de          <= 1'b0;
      pixel       <= '0;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hsync       <= s2.hs ^ SYNC_OFF;
      vsync       <= s2.vs ^ SYNC_OFF;
      de          <= s2.de;
      pixel       <= s2.de ? px_data : '0;
      vblank      <= s2.vb;
      frame_start <= s2.fs;
      if (s2.inc) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a reduced 8x4 raster (15x8 total).
// Frame buffer model returns addr[7:0] one clock after px_addr.
module tb_vga_scan_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int AW = $clog2(HA * VA);

  logic          pxclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] px_addr;
  logic [7:0]    px_data = '0;
  logic          hsync, vsync, de, vblank, frame_start;
  logic [7:0]    pixel;
  logic [15:0]   frame_count;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int   idx;
    logic de, hs, vs, vb, fs;
    int   fc;
  } vec_t;

  vga_scan_ctrl #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .PIXEL_DEPTH (8), .SYNC_ACTIVE_LOW (1)
  ) dut (
    .pxclk       (pxclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .px_addr     (px_addr),
    .px_data     (px_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pixel       (pixel),
    .vblank      (vblank),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) px_data <= 8'(px_addr);

  task automatic tick();
    @(posedge pxclk);
    @(negedge pxclk);
    cyc++;
  endtask

  task automatic run_to(int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // frame-relative scan index -> buffer address, -1 outside the visible area
  function automatic int ref_addr(int n);
    int h, v;
    if (n < 0) return -1;
    h = n % HT;
    v = (n / HT) % VT;
    if (v >= VA || h >= HA) return -1;
`ifdef VGA_SCAN_DOUBLE_EN
    return (v / 2) * (HA / 2) + h / 2;
`else
    return v * HA + h;
`endif
  endfunction

  function automatic logic [31:0] exp_pix(int n);
    int a;
    a = ref_addr(n);
    return (a < 0) ? 32'd0 : 32'(a & 255);
  endfunction

  task automatic chk_out(string tg, logic e_de, logic e_hs, logic e_vs,
                         logic e_vb, logic e_fs, int fc, int n);
    chk({tg, ".de"}, 32'(de), 32'(e_de));
    chk({tg, ".hsync"}, 32'(hsync), 32'(e_hs));
    chk({tg, ".vsync"}, 32'(vsync), 32'(e_vs));
    chk({tg, ".vblank"}, 32'(vblank), 32'(e_vb));
    chk({tg, ".fstart"}, 32'(frame_start), 32'(e_fs));
    chk({tg, ".fcount"}, 32'(frame_count), 32'(fc));
    chk({tg, ".pixel"}, 32'(pixel), exp_pix(n));
  endtask

  task automatic chk_reset(string tg);
    chk({tg, ".addr"}, 32'(px_addr), 32'd0);
    chk_out(tg, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);
  endtask

  initial begin
    vec_t tv[16];
    int   a;
    tv = '{
      '{0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0},
      '{1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{7,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{8,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
      '{12,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0},
      '{13,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{15,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{20,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{52,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0},
      '{60,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0},
      '{75,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0},
      '{85,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0},
      '{105, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0},
      '{119, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0},
      '{120, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1}
    };

    rst_n  = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    chk_reset("reset");

    rst_n = 1'b1;
    tick();
    base = cyc;

    for (int n = 1; n <= FT + 3; n++) begin
      tick();
      a = ref_addr(n - 1);
      chk("px_addr", 32'(px_addr), (a < 0) ? 32'd0 : 32'(a));
      foreach (tv[i]) begin
        if (tv[i].idx + 3 == n)
          chk_out($sformatf("vec%0d", tv[i].idx), tv[i].de, tv[i].hs,
                  tv[i].vs, tv[i].vb, tv[i].fs, tv[i].fc, tv[i].idx);
      end
    end

    run_to(base + 150);
    enable = 1'b0;
    run_to(base + 198);
    chk("drop.vsync", 32'(vsync), 32'd0);
    run_to(base + 243);
    chk_out("idle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, -1);
    chk("idle.addr", 32'(px_addr), 32'd0);
    run_to(base + 255);
    chk_out("idle2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, -1);

    run_to(base + 260);
    enable = 1'b1;
    tick();
    base = cyc;
    run_to(base + 2);
    chk("restart.lat", 32'(de), 32'd0);
    run_to(base + 3);
    chk_out("restart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0);
    run_to(base + 4);
    chk_out("restart1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
    run_to(base + FT + 3);
    chk_out("frame2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, FT);

    run_to(base + 150);
    rst_n = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    tick();
    base = cyc;
    run_to(base + 2);
    chk("midrst.lat", 32'(de), 32'd0);
    run_to(base + 3);
    chk_out("midrst.go", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    run_to(base + 4);
    chk("midrst.addr", 32'(px_addr), 32'(ref_addr(3)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
